param_dep_scheduler: RTL and testbench
======================================

Name: param_dep_scheduler

Overview:
- Hardware dependency scheduler for a table of up to N_NODES parameter nodes. Each node carries a dependency bitmask.
- Issues nodes one at a time, in dependency order, to an external evaluator over a valid/ready request channel plus a completion pulse.
- Detects unresolvable sets: self-reference, mutual reference, longer cycles and references to absent nodes. Reports the stuck nodes.
- Sits between the configuration loader and the shared parameter evaluator; it is the evaluator's only master.

Parameters:
N_NODES, 8, number of table entries (2..32)
IDX_W, $clog2(N_NODES), node index width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
cfg_we  in  1  write one table entry (ignored while busy)
cfg_idx  in  IDX_W  entry written
cfg_present  in  1  entry exists
cfg_deps  in  N_NODES  bit j set = entry depends on node j
start  in  1  begin scheduling pass (ignored while busy)
busy  out  1  pass in progress
done  out  1  pass completed, all present nodes evaluated
cycle_err  out  1  pass aborted, unresolvable nodes remain
stuck_mask  out  N_NODES  present, unevaluated nodes at abort
eval_valid  out  1  request to evaluator
eval_ready  in  1  evaluator accepts request
eval_idx  out  IDX_W  node to evaluate
eval_done  in  1  one-cycle pulse, outstanding evaluation finished
eval_count  out  IDX_W+1  nodes evaluated in current/last pass

Behaviour:
- Reset (async assert, sync deassert use): state IDLE; table present bits, deps and done_mask cleared; all outputs 0.
- Table writes: cfg_we in IDLE/DONE/ERR updates present[cfg_idx] and deps[cfg_idx] on the next edge. Writes while busy are dropped.
- start in IDLE/DONE/ERR: clear done_mask, eval_count, done, cycle_err, stuck_mask; go to SCAN; busy=1 from the next cycle. If start and cfg_we occur in the same cycle, the write lands first and the pass uses the updated table.
- ready[i] = present[i] & ~done_mask[i] & ((deps[i] & ~(done_mask & present)) == 0).
  - Consequence: a dependency on an absent node is never satisfied.
  - Consequence: a self bit (deps[i][i]) blocks node i.
- SCAN (1 cycle):
  - If any ready bit is set: latch the lowest ready index into eval_idx, go to ISSUE.
  - Else if (present & ~done_mask) == 0: go to DONE.
  - Else: stuck_mask <= present & ~done_mask, go to ERR.
- ISSUE: eval_valid=1 with eval_idx held stable until eval_ready is sampled high. On the handshake cycle go to WAIT; eval_valid drops the following cycle.
- WAIT: on eval_done, set done_mask[eval_idx], eval_count+1, go to SCAN.
  - eval_done outside WAIT is ignored.
  - eval_done in the same cycle as the handshake is ignored; the evaluator must not complete in zero cycles.
- DONE: done=1, busy=0; held until next start or reset.
- ERR: cycle_err=1, busy=0; stuck_mask held until next start or reset.
- Empty table (no present bits): start → SCAN → DONE, eval_count=0, no requests issued.
- Minimum per-node latency: SCAN(1) + ISSUE(≥1) + WAIT(≥1) = 3 cycles with eval_ready and eval_done tied high. The first eval_valid asserts 2 cycles after start.
- Only one request is ever outstanding. The order among independent nodes is strictly ascending index.
- rst_n asserted mid-pass: immediate return to IDLE, eval_valid drops asynchronously, table cleared.

Test Plan:
- Chain: node0 deps={}, node1 deps={0}, node2 deps={1}; start, evaluator ready/done in 1 cycle → eval_idx sequence 0,1,2; done=1, eval_count=3, cycle_err=0.
- Self-loop: node0 deps={0} only present → no eval_valid ever; cycle_err=1, stuck_mask=0x01, eval_count=0.
- Mixed cycle: node0 deps={1}, node1 deps={2,0}, node2 deps={1,3}, node3 deps={} → node3 evaluated, then abort; stuck_mask=0x07, eval_count=1.
- Missing dependency: node0 deps={5}, node5 absent, node1 deps={} → node1 evaluated; cycle_err=1, stuck_mask=0x01.
- Backpressure: chain of 2 with eval_ready low 4 cycles → eval_valid and eval_idx=0 held stable for all 4 cycles; a spurious eval_done pulse during ISSUE has no effect; final eval_count=2.
- Config while busy, plus reset: cfg_we to node7 during WAIT → table unchanged after pass. rst_n low during WAIT → busy, eval_valid, done and cycle_err all 0 immediately. A subsequent start with the table empty → done=1 within 2 cycles.

Source files
------------

// File: rtl/param_dep_scheduler.sv
// Dependency-ordered scheduler: issues present table nodes one at a time to an
// external evaluator once all their dependencies are evaluated, or reports a stuck set.

// One table entry: stored presence/dependency mask plus its ready term.
module param_dep_node #(
    parameter int N_NODES = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic               wr_present,
    input  logic [N_NODES-1:0] wr_deps,
    input  logic               node_done,
    input  logic [N_NODES-1:0] resolved,
    output logic               present,
    output logic               ready
);
    logic               present_q, present_d;
    logic [N_NODES-1:0] deps_q, deps_d;

    always_comb begin
        present_d = present_q;
        deps_d    = deps_q;
        if (wr_en) begin
            present_d = wr_present;
            deps_d    = wr_deps;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            present_q <= 1'b0;
            deps_q    <= '0;
        end else begin
            present_q <= present_d;
            deps_q    <= deps_d;
        end
    end

    // Only evaluated present nodes count as resolved, so a dependency on an
    // absent node or on the node itself can never be satisfied.
    assign present = present_q;
    assign ready   = present_q & ~node_done & ((deps_q & ~resolved) == '0);
endmodule

module param_dep_scheduler #(
    parameter int N_NODES = 8,
    parameter int IDX_W   = $clog2(N_NODES)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_idx,
    input  logic               cfg_present,
    input  logic [N_NODES-1:0] cfg_deps,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               cycle_err,
    output logic [N_NODES-1:0] stuck_mask,
    output logic               eval_valid,
    input  logic               eval_ready,
    output logic [IDX_W-1:0]   eval_idx,
    input  logic               eval_done,
    output logic [IDX_W:0]     eval_count
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    state_t             state_q, state_d;
    logic [N_NODES-1:0] done_mask_q, done_mask_d;
    logic [IDX_W-1:0]   eval_idx_q, eval_idx_d;
    logic [IDX_W:0]     eval_count_q, eval_count_d;
    logic               eval_valid_q, eval_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               cycle_err_q, cycle_err_d;
    logic [N_NODES-1:0] stuck_mask_q, stuck_mask_d;

    logic [N_NODES-1:0] present, ready, resolved, pending;
    logic               idle_like;
    logic [IDX_W-1:0]   low_idx;

    assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR);
    assign resolved  = done_mask_q & present;
    assign pending   = present & ~done_mask_q;

    for (genvar g = 0; g < N_NODES; g++) begin : g_node
        param_dep_node #(.N_NODES(N_NODES)) u_node (
            .clk        (clk),
            .rst_n      (rst_n),
            .wr_en      (cfg_we && idle_like && (cfg_idx == IDX_W'(g))),
            .wr_present (cfg_present),
            .wr_deps    (cfg_deps),
            .node_done  (done_mask_q[g]),
            .resolved   (resolved),
            .present    (present[g]),
            .ready      (ready[g])
        );
    end

    // Lowest ready index wins, giving strictly ascending order among independent nodes.
    always_comb begin
        low_idx = '0;
        for (int i = N_NODES - 1; i >= 0; i--) begin
            if (ready[i]) low_idx = IDX_W'(i);
        end
    end

    always_comb begin
        state_d      = state_q;
        done_mask_d  = done_mask_q;
        eval_idx_d   = eval_idx_q;
        eval_count_d = eval_count_q;
        stuck_mask_d = stuck_mask_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    done_mask_d  = '0;
                    eval_count_d = '0;
                    stuck_mask_d = '0;
                    state_d      = S_SCAN;
                end
            end
            S_SCAN: begin
                if (|ready) begin
                    eval_idx_d = low_idx;
                    state_d    = S_ISSUE;
                end else if (pending == '0) begin
                    state_d = S_DONE;
                end else begin
                    stuck_mask_d = pending;
                    state_d      = S_ERR;
                end
            end
            S_ISSUE: begin
                if (eval_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (eval_done) begin
                    done_mask_d[eval_idx_q] = 1'b1;
                    eval_count_d            = eval_count_q + (IDX_W+1)'(1);
                    state_d                 = S_SCAN;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Status outputs are registered copies of the next state.
        busy_d       = (state_d == S_SCAN) || (state_d == S_ISSUE) || (state_d == S_WAIT);
        eval_valid_d = (state_d == S_ISSUE);
        done_d       = (state_d == S_DONE);
        cycle_err_d  = (state_d == S_ERR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            done_mask_q  <= '0;
            eval_idx_q   <= '0;
            eval_count_q <= '0;
            eval_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cycle_err_q  <= 1'b0;
            stuck_mask_q <= '0;
        end else begin
            state_q      <= state_d;
            done_mask_q  <= done_mask_d;
            eval_idx_q   <= eval_idx_d;
            eval_count_q <= eval_count_d;
            eval_valid_q <= eval_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            cycle_err_q  <= cycle_err_d;
            stuck_mask_q <= stuck_mask_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign cycle_err  = cycle_err_q;
    assign stuck_mask = stuck_mask_q;
    assign eval_valid = eval_valid_q;
    assign eval_idx   = eval_idx_q;
    assign eval_count = eval_count_q;
endmodule

// File: tb/tb_param_dep_scheduler.sv
// Directed bench for param_dep_scheduler: chain, cycles, missing deps,
// backpressure, config-while-busy and mid-pass reset.
module tb_param_dep_scheduler;
    localparam int N = 8;
    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cfg_we = 1'b0;
    logic [W-1:0] cfg_idx = '0;
    logic         cfg_present = 1'b0;
    logic [N-1:0] cfg_deps = '0;
    logic         start = 1'b0;
    logic         busy, done, cycle_err;
    logic [N-1:0] stuck_mask;
    logic         eval_valid;
    logic         eval_ready = 1'b0;
    logic [W-1:0] eval_idx;
    logic         eval_done = 1'b0;
    logic [W:0]   eval_count;

    int total = 0;
    int bad = 0;
    int seq[$];

    always #5 clk = ~clk;

    param_dep_scheduler #(.N_NODES(N), .IDX_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_present(cfg_present), .cfg_deps(cfg_deps), .start(start),
        .busy(busy), .done(done), .cycle_err(cycle_err), .stuck_mask(stuck_mask),
        .eval_valid(eval_valid), .eval_ready(eval_ready), .eval_idx(eval_idx),
        .eval_done(eval_done), .eval_count(eval_count)
    );

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; cfg_we = 1'b0; start = 1'b0; eval_ready = 1'b0; eval_done = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic cfg_write(input int idx, input bit pres, input logic [N-1:0] deps);
        cfg_we = 1'b1; cfg_idx = W'(idx); cfg_present = pres; cfg_deps = deps;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic start_pass();
        seq.delete();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Evaluator that accepts at once and completes one cycle after the handshake.
    task automatic serve(input int max_cyc, output int cyc);
        bit pend;
        pend = 1'b0;
        cyc = -1;
        eval_ready = 1'b1;
        for (int i = 0; i < max_cyc; i++) begin
            if (done || cycle_err) begin
                cyc = i;
                break;
            end
            eval_done = pend;
            pend = 1'b0;
            if (eval_valid && eval_ready) begin
                seq.push_back(int'(eval_idx));
                pend = 1'b1;
            end
            step();
        end
        eval_done = 1'b0;
        if (cyc < 0) begin
            total++; bad++;
            $display("FAIL serve_timeout: no done/cycle_err within %0d cycles", max_cyc);
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0 || cycle_err !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b exp=00", done, cycle_err); end
        total++; if (eval_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", eval_valid); end
        total++; if (eval_count !== '0 || stuck_mask !== '0 || eval_idx !== '0) begin
            bad++; $display("FAIL reset_regs count=%0d stuck=%h idx=%0d exp=0", eval_count, stuck_mask, eval_idx);
        end
    endtask

    task automatic test_chain();
        int cyc;
        int exp_seq[3] = '{0, 1, 2};
        do_reset();
        cfg_write(0, 1, 8'h00);
        cfg_write(1, 1, 8'h01);
        cfg_write(2, 1, 8'h02);
        start_pass();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL chain_busy got=%b exp=1", busy); end
        total++; if (eval_valid !== 1'b0) begin bad++; $display("FAIL chain_scan_valid got=%b exp=0", eval_valid); end
        step();
        total++; if (eval_valid !== 1'b1 || eval_idx !== 3'd0) begin
            bad++; $display("FAIL chain_first_req valid=%b idx=%0d exp=1/0", eval_valid, eval_idx);
        end
        serve(100, cyc);
        total++; if (seq.size() != 3) begin bad++; $display("FAIL chain_len got=%0d exp=3", seq.size()); end
        for (int i = 0; i < 3 && i < seq.size(); i++) begin
            total++; if (seq[i] != exp_seq[i]) begin bad++; $display("FAIL chain_order[%0d] got=%0d exp=%0d", i, seq[i], exp_seq[i]); end
        end
        // cyc counts from the cycle after the start pass was already in SCAN+ISSUE.
        total++; if (cyc != 9) begin bad++; $display("FAIL chain_latency got=%0d exp=9", cyc); end
        total++; if (done !== 1'b1 || cycle_err !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL chain_status done=%b err=%b busy=%b exp=1/0/0", done, cycle_err, busy);
        end
        total++; if (eval_count !== 4'd3) begin bad++; $display("FAIL chain_count got=%0d exp=3", eval_count); end
        // Back-to-back restart from DONE gives the same result.
        start_pass();
        total++; if (done !== 1'b0 || eval_count !== 4'd0) begin
            bad++; $display("FAIL b2b_clear done=%b count=%0d exp=0/0", done, eval_count);
        end
        serve(100, cyc);
        total++; if (eval_count !== 4'd3 || done !== 1'b1) begin
            bad++; $display("FAIL b2b_count count=%0d done=%b exp=3/1", eval_count, done);
        end
    endtask

    task automatic test_self_loop();
        int cyc;
        do_reset();
        cfg_write(0, 1, 8'h01);
        start_pass();
        serve(50, cyc);
        total++; if (seq.size() != 0) begin bad++; $display("FAIL self_no_req got=%0d reqs exp=0", seq.size()); end
        total++; if (cycle_err !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL self_err err=%b done=%b exp=1/0", cycle_err, done); end
        total++; if (stuck_mask !== 8'h01) begin bad++; $display("FAIL self_stuck got=%h exp=01", stuck_mask); end
        total++; if (eval_count !== 4'd0 || cyc != 1) begin bad++; $display("FAIL self_count count=%0d cyc=%0d exp=0/1", eval_count, cyc); end
    endtask

    task automatic test_mixed_cycle();
        int cyc;
        do_reset();
        cfg_write(0, 1, 8'h02);
        cfg_write(1, 1, 8'h05);
        cfg_write(2, 1, 8'h0A);
        cfg_write(3, 1, 8'h00);
        start_pass();
        serve(100, cyc);
        total++; if (seq.size() != 1 || (seq.size() > 0 && seq[0] != 3)) begin
            bad++; $display("FAIL mixed_seq len=%0d first=%0d exp=1/3", seq.size(), (seq.size() > 0) ? seq[0] : -1);
        end
        total++; if (cycle_err !== 1'b1 || stuck_mask !== 8'h07) begin
            bad++; $display("FAIL mixed_stuck err=%b stuck=%h exp=1/07", cycle_err, stuck_mask);
        end
        total++; if (eval_count !== 4'd1) begin bad++; $display("FAIL mixed_count got=%0d exp=1", eval_count); end
    endtask

    task automatic test_missing_dep();
        int cyc;
        do_reset();
        cfg_write(0, 1, 8'h20);
        cfg_write(1, 1, 8'h00);
        start_pass();
        serve(100, cyc);
        total++; if (seq.size() != 1 || (seq.size() > 0 && seq[0] != 1)) begin
            bad++; $display("FAIL missing_seq len=%0d exp=1 (node1)", seq.size());
        end
        total++; if (cycle_err !== 1'b1 || stuck_mask !== 8'h01) begin
            bad++; $display("FAIL missing_stuck err=%b stuck=%h exp=1/01", cycle_err, stuck_mask);
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        do_reset();
        cfg_write(0, 1, 8'h00);
        cfg_write(1, 1, 8'h01);
        eval_ready = 1'b0;
        start_pass();
        step();
        for (int k = 0; k < 4; k++) begin
            total++; if (eval_valid !== 1'b1 || eval_idx !== 3'd0) begin
                bad++; $display("FAIL bp_hold[%0d] valid=%b idx=%0d exp=1/0", k, eval_valid, eval_idx);
            end
            eval_done = (k == 1);
            step();
        end
        eval_done = 1'b0;
        total++; if (eval_count !== 4'd0) begin bad++; $display("FAIL bp_spurious count=%0d exp=0", eval_count); end
        eval_ready = 1'b1;
        step();
        total++; if (eval_valid !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL bp_drop valid=%b busy=%b exp=0/1", eval_valid, busy);
        end
        eval_done = 1'b1;
        step();
        eval_done = 1'b0;
        serve(100, cyc);
        total++; if (seq.size() != 1 || (seq.size() > 0 && seq[0] != 1)) begin
            bad++; $display("FAIL bp_second len=%0d exp=1 (node1)", seq.size());
        end
        total++; if (eval_count !== 4'd2 || done !== 1'b1) begin
            bad++; $display("FAIL bp_final count=%0d done=%b exp=2/1", eval_count, done);
        end
    endtask

    task automatic test_cfg_busy_reset();
        do_reset();
        cfg_write(0, 1, 8'h00);
        start_pass();
        eval_ready = 1'b1;
        step();
        step();
        cfg_write(7, 1, 8'h00);
        eval_done = 1'b1;
        step();
        eval_done = 1'b0;
        step();
        total++; if (done !== 1'b1 || eval_count !== 4'd1) begin
            bad++; $display("FAIL cfgbusy_pass1 done=%b count=%0d exp=1/1", done, eval_count);
        end
        start_pass();
        step();
        step();
        total++; if (busy !== 1'b1 || eval_valid !== 1'b0) begin
            bad++; $display("FAIL cfgbusy_wait busy=%b valid=%b exp=1/0", busy, eval_valid);
        end
        rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || eval_valid !== 1'b0 || done !== 1'b0 || cycle_err !== 1'b0) begin
            bad++; $display("FAIL midreset busy=%b valid=%b done=%b err=%b exp=0000", busy, eval_valid, done, cycle_err);
        end
        step();
        rst_n = 1'b1;
        eval_ready = 1'b0;
        start_pass();
        step();
        total++; if (done !== 1'b1 || eval_count !== 4'd0 || cycle_err !== 1'b0) begin
            bad++; $display("FAIL empty_pass done=%b count=%0d err=%b exp=1/0/0", done, eval_count, cycle_err);
        end
    endtask

    initial begin
        test_reset();
        test_chain();
        test_self_loop();
        test_mixed_cycle();
        test_missing_dep();
        test_backpressure();
        test_cfg_busy_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
